// File: rtl/i2c_slave_phy_pkg.sv
// Shared definitions for the I2C slave bit engine: state encoding, constants
// and default parameter values.
package i2c_slave_phy_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_e;

    localparam logic [7:0] ZERO8 = 8'h00;
    localparam int RW_BIT = 0;
    localparam int DEF_FILTER_LEN = 3;
    localparam int DEF_HOLD_CYCLES = 4;

    // General call (all-zero address) is never claimed.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own);
        return (addr_byte[7:1] == own) && (addr_byte[7:1] != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_slave_phy_line_filter.sv
// Pin conditioning for one I2C line: 2-FF synchroniser, stability filter that
// needs FILTER_LEN consecutive differing samples, and single-cycle edge strobes.
module i2c_line_filter
    import i2c_slave_phy_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = 3'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == 3'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_phy.sv
// Bit-level I2C slave: START/STOP detection, 7-bit address match, byte shift
// in/out with ACK generation, and fixed-length received/sended pulses.
//   state     | meaning
//   IDLE      | bus free, waiting for START
//   ADDR      | shifting in address + R/W
//   ADDR_ACK  | driving address ACK, then branch to RX or TX
//   RX/RX_ACK | receiving a write byte / driving its ACK
//   TX/TX_ACK | shifting out a read byte / sampling master ACK
//   WAIT_STOP | not addressed or NACKed, ignore until START/STOP
module i2c_slave_phy
    import i2c_slave_phy_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] address,
    input  logic [7:0] datasend,
    output logic       sended,
    output logic [7:0] datareceive,
    output logic       received,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_ev, stop_ev;

    state_e        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rxdata_q, rxdata_d;
    logic          oe_q, oe_d;
    logic          rw_q, rw_d;
    logic          phase_q, phase_d;
    logic          busy_q, busy_d;
    logic [HW-1:0] rec_cnt_q, rec_cnt_d;
    logic [HW-1:0] snd_cnt_q, snd_cnt_d;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset(reset), .pin_i(scl_in),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset(reset), .pin_i(sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start_ev = sda_fall & scl_lvl;
    assign stop_ev  = sda_rise & scl_lvl;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rxdata_d  = rxdata_q;
        oe_d      = oe_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        busy_d    = busy_q;
        rec_cnt_d = (rec_cnt_q != '0) ? rec_cnt_q - HW'(1) : '0;
        snd_cnt_d = (snd_cnt_q != '0) ? snd_cnt_q - HW'(1) : '0;

        if (start_ev) begin
            state_d  = ADDR;
            bitcnt_d = 4'd0;
            oe_d     = 1'b0;
            phase_d  = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_ev) begin
            state_d  = IDLE;
            bitcnt_d = 4'd0;
            oe_d     = 1'b0;
            phase_d  = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_lvl};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = 4'd0;
                            rw_d     = shift_d[RW_BIT];
                            state_d  = addr_match(shift_d, address) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    // First fall ends the R/W bit, second fall ends the ACK clock.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d  = 1'b0;
                            bitcnt_d = 4'd0;
                            if (rw_q) begin
                                state_d = TX;
                                shift_d = datasend;
                                oe_d    = ~datasend[7];
                            end else begin
                                state_d = RX;
                                oe_d    = 1'b0;
                            end
                        end
                    end
                end
                RX: begin
                    oe_d = 1'b0;
                    if (scl_rise && bitcnt_q != 4'd8) begin
                        shift_d  = {shift_q[6:0], sda_lvl};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            rxdata_d  = shift_d;
                            rec_cnt_d = HW'(HOLD_CYCLES);
                        end
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        state_d  = RX_ACK;
                        oe_d     = 1'b1;
                        bitcnt_d = 4'd0;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_d = RX;
                        oe_d    = 1'b0;
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd7) begin
                            state_d   = TX_ACK;
                            oe_d      = 1'b0;
                            bitcnt_d  = 4'd0;
                            phase_d   = 1'b0;
                            snd_cnt_d = HW'(HOLD_CYCLES);
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            oe_d     = ~shift_d[7];
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) state_d = WAIT_STOP;
                        else         phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        state_d = TX;
                        shift_d = datasend;
                        oe_d    = ~datasend[7];
                    end
                end
                WAIT_STOP: oe_d = 1'b0;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bitcnt_q  <= 4'd0;
            shift_q   <= ZERO8;
            rxdata_q  <= ZERO8;
            oe_q      <= 1'b0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b0;
            rec_cnt_q <= '0;
            snd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            rxdata_q  <= rxdata_d;
            oe_q      <= oe_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            rec_cnt_q <= rec_cnt_d;
            snd_cnt_q <= snd_cnt_d;
        end
    end

    assign sda_oe      = oe_q;
    assign datareceive = rxdata_q;
    assign received    = (rec_cnt_q != '0);
    assign sended      = (snd_cnt_q != '0);
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_phy.sv
// Bench for i2c_slave_phy: a bit-banged I2C master with expected events queued
// into a scoreboard that independent monitors drain on received/sended pulses.
module tb_i2c_slave_phy;
    import i2c_slave_phy_pkg::*;

    localparam int Q    = 8;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [6:0] address = 7'h3C;
    logic [7:0] datasend = 8'h00;
    logic       sda_oe, sended, received, busy;
    logic [7:0] datareceive;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_phy #(.FILTER_LEN(3), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .address(address), .datasend(datasend),
        .sended(sended), .datareceive(datareceive), .received(received),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] snd_exp[$];
    logic [7:0] pay[4];
    logic oe_seen = 1'b0;
    logic watch_busy = 1'b0;
    logic busy_drop = 1'b0;

    always @(posedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (watch_busy && !busy) busy_drop = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: the slave claims a frame when the upper seven bits equal its address, never 0.
    function automatic bit model_match(input logic [7:0] ab, input logic [6:0] own);
        int a;
        a = int'(ab) / 2;
        return (a == int'(own)) && (a != 0);
    endfunction

    task automatic mstart();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic mstop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(Q);
    endtask

    task automatic mbit(input logic b, input bit glitch, output logic got);
        sda_m = b; wclk(Q);
        scl_m = 1'b1;
        if (glitch) begin
            wclk(4); scl_m = 1'b0; wclk(2); scl_m = 1'b1; wclk(Q - 6);
        end else begin
            wclk(Q);
        end
        got = sda_line; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic mbyte_w(input logic [7:0] b, input bit glitch, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) mbit(b[i], glitch && (i == 4), g);
        mbit(1'b1, 1'b0, g);
        ack = ~g;
    endtask

    task automatic mbyte_r(input logic ack_m, input logic [7:0] next_ds, output logic [7:0] d);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            mbit(1'b1, 1'b0, g);
            d[i] = g;
        end
        datasend = next_ds;
        mbit(~ack_m, 1'b0, g);
    endtask

    task automatic write_txn(input logic [7:0] ab, input int n, input bit do_stop);
        logic ack;
        bit m;
        m = model_match(ab, address);
        mstart();
        chk("busy_after_start", busy, 1'b1);
        mbyte_w(ab, 1'b0, ack);
        chk("wr_addr_ack", ack, m);
        for (int k = 0; k < n; k++) begin
            if (m) rx_exp.push_back(pay[k]);
            mbyte_w(pay[k], 1'b0, ack);
            chk("wr_data_ack", ack, m);
        end
        if (do_stop) mstop();
    endtask

    task automatic read_txn(input logic [7:0] ab, input int n, input bit do_stop);
        logic ack;
        logic [7:0] d;
        bit m;
        m = model_match(ab, address);
        datasend = pay[0];
        mstart();
        mbyte_w(ab, 1'b0, ack);
        chk("rd_addr_ack", ack, m);
        for (int k = 0; k < n; k++) begin
            if (m) snd_exp.push_back(pay[k]);
            mbyte_r(k != n - 1, pay[(k + 1) % 4], d);
            chk("rd_data", d, m ? pay[k] : 8'hFF);
        end
        wclk(2);
        chk("rd_release_after_nack", sda_oe, 1'b0);
        if (do_stop) mstop();
    endtask

    initial begin : mon_rx
        int w;
        logic [7:0] e;
        forever begin
            @(posedge received);
            #1;
            if (rx_exp.size() == 0) begin
                tot++; bad++;
                $display("FAIL rx_unexpected actual=%0h required=none", datareceive);
            end else begin
                e = rx_exp.pop_front();
                chk("rx_data", datareceive, e);
            end
            chk("rx_no_overlap", sended, 1'b0);
            w = 0;
            do begin
                w++;
                @(posedge clk); #1;
            end while (received && w < 100);
            chk("rx_width", w, HOLD);
        end
    end

    initial begin : mon_tx
        int w;
        logic [7:0] e;
        forever begin
            @(posedge sended);
            #1;
            if (snd_exp.size() == 0) begin
                tot++; bad++;
                $display("FAIL tx_unexpected actual=pulse required=none");
            end else begin
                e = snd_exp.pop_front();
            end
            chk("tx_no_overlap", received, 1'b0);
            w = 0;
            do begin
                w++;
                @(posedge clk); #1;
            end while (sended && w < 100);
            chk("tx_width", w, HOLD);
        end
    end

    initial begin : watchdog
        #800000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin : main
        logic g, ack;
        logic [7:0] ab;
        int n;

        reset = 1'b0;
        wclk(3);
        reset = 1'b1;
        wclk(2);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_received", received, 1'b0);
        chk("rst_sended", sended, 1'b0);
        chk("rst_datareceive", datareceive, 8'h00);

        // Matched write of one data byte.
        pay[0] = 8'hA5;
        write_txn(8'h78, 1, 1'b1);
        wclk(10);
        chk("wr_datareceive", datareceive, 8'hA5);
        chk("busy_after_stop", busy, 1'b0);

        // Foreign address: never driven, parked in WAIT_STOP.
        oe_seen = 1'b0;
        pay[0] = 8'h33;
        write_txn(8'h7A, 1, 1'b0);
        chk("foreign_no_oe", oe_seen, 1'b0);
        chk("foreign_state", dut.state_q, WAIT_STOP);
        mstop();

        // Read two bytes, ACK then NACK.
        pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'hC3;
        read_txn(8'h79, 2, 1'b1);

        // Write then repeated START into read, no STOP in between.
        pay[0] = 8'h11;
        write_txn(8'h78, 1, 1'b0);
        busy_drop = 1'b0;
        watch_busy = 1'b1;
        pay[0] = 8'h96; pay[1] = 8'h96;
        read_txn(8'h79, 1, 1'b0);
        watch_busy = 1'b0;
        chk("rs_busy_held", busy_drop, 1'b0);
        chk("rs_datareceive", datareceive, 8'h11);
        mstop();

        // Reset while the slave is driving the address ACK.
        mstart();
        for (int i = 7; i >= 0; i--) begin
            ab = 8'h78;
            mbit(ab[i], 1'b0, g);
        end
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q / 2);
        chk("ack_oe_before_reset", sda_oe, 1'b1);
        reset = 1'b0;
        wclk(1);
        chk("oe_after_reset", sda_oe, 1'b0);
        reset = 1'b1;
        wclk(Q + Q / 2);
        scl_m = 1'b0; wclk(Q);
        oe_seen = 1'b0;
        mbyte_w(8'h78, 1'b0, ack);
        chk("post_reset_ignored", ack, 1'b0);
        chk("post_reset_no_oe", oe_seen, 1'b0);
        mstop();

        // SCL glitch in the middle of a received byte.
        mstart();
        mbyte_w(8'h78, 1'b0, ack);
        chk("gl_addr_ack", ack, 1'b1);
        rx_exp.push_back(8'h3C);
        mbyte_w(8'h3C, 1'b1, ack);
        chk("gl_byte_ack", ack, 1'b1);
        rx_exp.push_back(8'hA5);
        mbyte_w(8'hA5, 1'b0, ack);
        chk("gl_next_ack", ack, 1'b1);
        mstop();

        // Randomised frames.
        for (int t = 0; t < 8; t++) begin
            address = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 3) != 0) ab = {address, 1'($urandom_range(0, 1))};
            else                           ab = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) pay[k] = 8'($urandom_range(0, 255));
            if (ab[0]) read_txn(ab, n, 1'b1);
            else       write_txn(ab, n, 1'b1);
            wclk(20);
        end

        wclk(50);
        chk("rx_queue_drained", rx_exp.size(), 0);
        chk("tx_queue_drained", snd_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
